// File: rtl/i2s_pkg.sv
// Shared constants and FSM state type for the I2S transmit path.
package i2s_pkg;
  localparam int SLOT_BITS  = 16;
  localparam int FRAME_BITS = 2 * SLOT_BITS;
  localparam int RD_SLOT    = FRAME_BITS - 3;
  localparam int LATCH_SLOT = FRAME_BITS - 1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} i2sTxState_t;
endpackage

// File: rtl/i2s_clk_gen.sv
// BCLK divider: toggles o_bclk every HALF_DIV clk_i cycles while i_run is high,
// and flags the cycle in which BCLK is about to fall.
module i2s_clk_gen #(
  parameter int HALF_DIV = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic i_run,
  output logic o_bclk,
  output logic o_fall
);
  localparam int DW = $clog2(HALF_DIV);
  localparam logic [DW-1:0] DIV_TC = DW'(HALF_DIV - 1);

  logic [DW-1:0] r_divCnt;
  logic          r_bclk;
  logic          w_tc;

  assign w_tc   = i_run && (r_divCnt == DIV_TC);
  assign o_fall = w_tc && r_bclk;
  assign o_bclk = r_bclk;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_divCnt <= '0;
      r_bclk   <= 1'b0;
    end else if (!i_run) begin
      r_divCnt <= '0;
    end else if (w_tc) begin
      r_divCnt <= '0;
      r_bclk   <= ~r_bclk;
    end else begin
      r_divCnt <= r_divCnt + 1'b1;
    end
  end
endmodule

// File: rtl/i2s_tx_serializer.sv
// Philips I2S master transmitter: pulls one mono sample per frame from the
// FWFT FIFO and sends it on both L and R slots, MSB first.
module i2s_tx_serializer
  import i2s_pkg::*;
#(
  parameter int PKT_WIDTH     = SLOT_BITS,
  parameter int BCLK_HALF_DIV = 2
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 en_i,
  input  logic [PKT_WIDTH-1:0] pkt_i,
  input  logic                 pktValid_i,
  output logic                 rdEN_o,
  output logic                 bclk_o,
  output logic                 lrclk_o,
  output logic                 sdata_o,
  output logic                 repeat_o,
  output logic                 busy_o
);
  localparam int FRAME_N = 2 * PKT_WIDTH;
  localparam int BW      = $clog2(FRAME_N);
  localparam logic [BW-1:0] B_RD    = BW'(FRAME_N - (FRAME_BITS - RD_SLOT));
  localparam logic [BW-1:0] B_LATCH = BW'(FRAME_N - (FRAME_BITS - LATCH_SLOT));
  localparam logic [BW-1:0] B_RSLOT = BW'(PKT_WIDTH);
  localparam logic [BW-1:0] B_LR_HI = BW'(PKT_WIDTH - 1);

  i2sTxState_t          r_state;
  logic [BW-1:0]        r_bitCnt;
  logic [PKT_WIDTH-1:0] r_latch, r_shreg;
  logic                 r_lrclk, r_sdata, r_rden, r_repeat, r_seen;
  logic                 w_fall;
  logic [BW-1:0]        w_nextBit;

  i2s_clk_gen #(.HALF_DIV(BCLK_HALF_DIV)) u_clk (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .i_run  (r_state != IDLE),
    .o_bclk (bclk_o),
    .o_fall (w_fall)
  );

  assign w_nextBit = (r_bitCnt == B_LATCH) ? '0 : r_bitCnt + 1'b1;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state  <= IDLE;
      r_bitCnt <= B_LATCH;
      r_lrclk  <= 1'b1;
      r_sdata  <= 1'b0;
      r_rden   <= 1'b0;
      r_repeat <= 1'b0;
      r_latch  <= '0;
      r_shreg  <= '0;
      r_seen   <= 1'b0;
    end else begin
      r_rden   <= 1'b0;
      r_repeat <= 1'b0;
      if (pktValid_i) r_seen <= 1'b1;
      case (r_state)
        IDLE: if (en_i) r_state <= RUN;
        RUN, DRAIN: begin
          if (w_fall) begin
            if (r_state == DRAIN && w_nextBit == B_LATCH) begin
              // Last slot bit is dropped; park the bus and clear the latch so
              // the next run starts with a silent frame.
              r_state  <= IDLE;
              r_bitCnt <= B_LATCH;
              r_lrclk  <= 1'b1;
              r_sdata  <= 1'b0;
              r_latch  <= '0;
              r_shreg  <= '0;
            end else begin
              r_bitCnt <= w_nextBit;
              if (w_nextBit == B_LATCH)      r_lrclk <= 1'b0;
              else if (w_nextBit == B_LR_HI) r_lrclk <= 1'b1;
              if (w_nextBit == '0 || w_nextBit == B_RSLOT) begin
                r_sdata <= r_latch[PKT_WIDTH-1];
                r_shreg <= {r_latch[PKT_WIDTH-2:0], 1'b0};
              end else begin
                r_sdata <= r_shreg[PKT_WIDTH-1];
                r_shreg <= {r_shreg[PKT_WIDTH-2:0], 1'b0};
              end
              if (r_state == RUN && w_nextBit == B_RD) r_rden <= 1'b1;
              if (r_state == RUN && w_nextBit == B_LATCH) begin
                r_latch  <= pkt_i;
                r_seen   <= 1'b0;
                r_repeat <= !(r_seen || pktValid_i);
                if (!en_i) r_state <= DRAIN;
              end
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rdEN_o   = r_rden;
  assign lrclk_o  = r_lrclk;
  assign sdata_o  = r_sdata;
  assign repeat_o = r_repeat;
  assign busy_o   = (r_state != IDLE);
endmodule

// File: tb/tb_i2s_tx_serializer.sv
// Directed bench: decodes the I2S stream independently and checks words,
// strobes, drain and async reset behaviour.
module tb_i2s_tx_serializer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        en = 1'b0;
  logic [15:0] pkt = '0;
  logic        pkt_valid = 1'b0;
  logic        rden, bclk, lrclk, sdata, rep, busy;

  i2s_tx_serializer #(.PKT_WIDTH(16), .BCLK_HALF_DIV(2)) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .en_i       (en),
    .pkt_i      (pkt),
    .pktValid_i (pkt_valid),
    .rdEN_o     (rden),
    .bclk_o     (bclk),
    .lrclk_o    (lrclk),
    .sdata_o    (sdata),
    .repeat_o   (rep),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk = 0, n_pass = 0;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
  endtask

  // Independent I2S receiver: a word completes on the rise where LRCLK changes.
  logic [15:0] wq[$];
  logic [15:0] sh = '0;
  logic        prev_b = 1'b0, prev_lr = 1'b1, lr_chk = 1'b0, lr_armed = 1'b0;
  int          rcnt = 0, n_rep = 0, n_rd = 0;

  always @(negedge clk) begin
    if (rst) begin
      prev_lr = 1'b1;
      prev_b  = 1'b0;
    end else begin
      if (rep)  n_rep++;
      if (rden) n_rd++;
      if (bclk && !prev_b) begin
        sh = {sh[14:0], sdata};
        if (lrclk != prev_lr) begin
          if (lr_chk && lr_armed) chk("lrclk_len", rcnt, 16);
          lr_armed = 1'b1;
          wq.push_back(sh);
          rcnt = 1;
        end else rcnt++;
        prev_lr = lrclk;
      end
      if (!lr_chk) lr_armed = 1'b0;
      prev_b = bclk;
    end
  end

  function automatic logic [15:0] qget(input int k);
    if (k < wq.size()) return wq[k];
    return 'x;
  endfunction

  task automatic wait_rden(output int c);
    int n = 0;
    @(negedge clk);
    while (!rden && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("rden_seen", {31'b0, rden}, 32'd1);
    c = cyc;
    @(negedge clk);
    chk("rden_width", {31'b0, rden}, 32'd0);
  endtask

  task automatic pulse_valid(input logic [15:0] v);
    pkt = v;
    pkt_valid = 1'b1;
    @(negedge clk);
    pkt_valid = 1'b0;
  endtask

  typedef struct {
    logic [15:0] pkt;
    bit          vld;
    logic [15:0] exp_w;
    int          exp_rep;
  } vec_t;

  vec_t tbl[9];
  int   c, lastc, rep0, rd0, n;

  initial begin
    tbl[0] = '{16'hA5C3, 1'b1, 16'hA5C3, 0};
    tbl[1] = '{16'hA5C3, 1'b1, 16'hA5C3, 0};
    tbl[2] = '{16'h1234, 1'b0, 16'h1234, 1};
    tbl[3] = '{16'h1234, 1'b0, 16'h1234, 1};
    tbl[4] = '{16'h1234, 1'b0, 16'h1234, 1};
    tbl[5] = '{16'h8000, 1'b1, 16'h8000, 0};
    tbl[6] = '{16'h7FFF, 1'b1, 16'h7FFF, 0};
    tbl[7] = '{16'hFFFF, 1'b1, 16'hFFFF, 0};
    tbl[8] = '{16'h0001, 1'b1, 16'h0001, 0};

    repeat (3) @(negedge clk);
    chk("reset_outs", {26'b0, bclk, lrclk, sdata, rden, rep, busy}, 32'b010000);
    rst = 1'b0;
    en  = 1'b1;
    wq.delete();
    lr_chk = 1'b1;
    repeat (2) @(negedge clk);
    chk("busy_run", {31'b0, busy}, 32'd1);

    // Vector i is handed over after the rdEN of frame i+1 and plays in frame i+2.
    lastc = 0;
    rep0  = 0;
    for (int i = 0; i < 9; i++) begin
      wait_rden(c);
      if (i > 0) begin
        chk("rden_period", c - lastc, 128);
        chk("repeat_cnt", n_rep - rep0, tbl[i-1].exp_rep);
      end
      lastc = c;
      rep0  = n_rep;
      if (tbl[i].vld) pulse_valid(tbl[i].pkt);
      else pkt = tbl[i].pkt;
    end
    wait_rden(c);
    chk("rden_period", c - lastc, 128);
    chk("repeat_cnt", n_rep - rep0, tbl[8].exp_rep);
    repeat (16) @(negedge clk);
    lr_chk = 1'b0;

    chk("word_cnt", {31'b0, wq.size() >= 19}, 32'd1);
    chk("first_R_zero", {16'b0, qget(0)}, 32'h0);
    for (int i = 0; i < 9; i++) begin
      chk("word_L", {16'b0, qget(2*i+1)}, {16'b0, tbl[i].exp_w});
      chk("word_R", {16'b0, qget(2*i+2)}, {16'b0, tbl[i].exp_w});
    end

    // Drain: drop en mid-frame, current frame plus one more go out.
    wait_rden(c);
    pulse_valid(16'hBEEF);
    repeat (52) @(negedge clk);
    en = 1'b0;
    wq.delete();
    rd0 = n_rd;
    wait_rden(c);
    pulse_valid(16'hC0DE);
    repeat (20) @(negedge clk);
    en = 1'b1;
    repeat (4) @(negedge clk);
    en = 1'b0;
    chk("busy_drain", {31'b0, busy}, 32'd1);
    n = 0;
    while (busy && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("drain_done", {31'b0, n < 400}, 32'd1);
    chk("drain_rden_cnt", n_rd - rd0, 1);
    chk("drain_words", wq.size(), 3);
    chk("drain_L_F", {16'b0, qget(0)}, 32'hBEEF);
    chk("drain_R_F", {16'b0, qget(1)}, 32'hBEEF);
    chk("drain_L_last", {16'b0, qget(2)}, 32'hC0DE);
    chk("idle_outs", {26'b0, bclk, lrclk, sdata, rden, rep, busy}, 32'b010000);
    repeat (40) @(negedge clk);
    chk("idle_hold", {29'b0, bclk, busy, n_rd - rd0 == 1}, 32'b001);

    // Async reset mid-slot, then restart from a clean latch.
    en = 1'b1;
    wait_rden(c);
    pulse_valid(16'h5A5A);
    wait_rden(c);
    repeat (40) @(negedge clk);
    #1 rst = 1'b1;
    #1 chk("async_reset", {26'b0, bclk, lrclk, sdata, rden, rep, busy}, 32'b010000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wq.delete();
    wait_rden(c);
    pulse_valid(16'h3C3C);
    wait_rden(c);
    repeat (12) @(negedge clk);
    chk("restart_R_zero", {16'b0, qget(0)}, 32'h0);
    chk("restart_L", {16'b0, qget(1)}, 32'h3C3C);
    chk("restart_R", {16'b0, qget(2)}, 32'h3C3C);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
